nf10_decap_input_arbiter: RTL and testbench

Packet-granular round-robin arbiter sharing one nf10_decap engine between C_NUM_PORTS AXI4-Stream sources. Sits directly upstream of nf10_decap: picks one requesting port, forwards that port's whole packet (through tlast) unmodified, then re-arbitrates. Output passes through a 2-entry register slice, so every master signal and every s_axis_tready is driven from a flop. Per-port accepted-packet counters are exported for the stats block.

---
 rtl/nf10_decap_input_arbiter_pkg.sv | 16 +
 rtl/nf10_axis_reg_slice.sv | 42 ++++
 rtl/nf10_decap_input_arbiter.sv | 106 ++++++++++
 tb/tb_nf10_decap_input_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nf10_decap_input_arbiter_pkg.sv
// nf10_decap_input_arbiter_pkg: arbiter state encoding, tuser field layout and a log2 helper
package nf10_decap_input_arbiter_pkg;
    typedef enum logic {IDLE = 1'b0, PKT = 1'b1} arb_state_e;
    typedef struct packed {
        logic [95:0] rsvd;
        logic [7:0]  dst;
        logic [7:0]  src;
        logic [15:0] len;
    } nf10_tuser_t;
    function automatic int log2c(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/nf10_axis_reg_slice.sv
// nf10_axis_reg_slice: 2-entry skid buffer whose outputs all come straight from flops
module nf10_axis_reg_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data_i,
    input  logic         in_valid_i,
    output logic         in_room_nxt_o,
    output logic [W-1:0] out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);
    logic [1:0]   count_q, count_d;
    logic [W-1:0] head_q, skid_q;
    logic         ready_q, valid_q, push, pop, wr_head;
    always_comb begin
        push    = in_valid_i & ready_q;
        pop     = valid_q & out_ready_i;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        wr_head = push & (count_q == 2'd0 || (count_q == 2'd1 && pop));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 2'd0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            count_q <= count_d;
            ready_q <= count_d != 2'd2;
            valid_q <= count_d != 2'd0;
            if (pop && count_q == 2'd2) head_q <= skid_q;
            else if (wr_head) head_q <= in_data_i;
            if (push && !wr_head) skid_q <= in_data_i;
        end
    end
    assign in_room_nxt_o = count_d != 2'd2;
    assign out_data_o    = head_q;
    assign out_valid_o   = valid_q;
endmodule

// File: rtl/nf10_decap_input_arbiter.sv
// nf10_decap_input_arbiter: packet-granular round-robin mux of C_NUM_PORTS AXI4-Stream
// sources into one nf10_decap engine, with per-port accepted-packet counters.
module nf10_decap_input_arbiter
    import nf10_decap_input_arbiter_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_PORTS          = 4
) (
    input  logic                                          axi_aclk,
    input  logic                                          axi_reset,
    input  logic [C_NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_NUM_PORTS*C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic [C_NUM_PORTS-1:0]                        s_axis_tvalid,
    input  logic [C_NUM_PORTS-1:0]                        s_axis_tlast,
    output logic [C_NUM_PORTS-1:0]                        s_axis_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]                m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]              m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]               m_axis_tuser,
    output logic                                          m_axis_tvalid,
    output logic                                          m_axis_tlast,
    input  logic                                          m_axis_tready,
    output logic [C_NUM_PORTS*32-1:0]                     pkt_cnt
);
    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;
    localparam int N  = C_NUM_PORTS;
    localparam int GW = log2c(N);
    localparam int PW = DW + SW + UW + 1;

    arb_state_e       state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d, last_q, last_d, pick, idx;
    logic [N-1:0]     tready_q, tready_d;
    logic [N*32-1:0]  cnt_q, cnt_d;
    logic             found, accept, room_nxt;
    logic [PW-1:0]    beat;

    // Walk last+1 .. last+N downward so the nearest requester after last_grant wins.
    always_comb begin
        pick  = last_q;
        idx   = last_q;
        found = 1'b0;
        for (int i = N; i >= 1; i--) begin
            idx = GW'((int'(last_q) + i) % N);
            if (s_axis_tvalid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign accept = |(s_axis_tvalid & tready_q);
    assign beat   = {s_axis_tlast[grant_q], s_axis_tuser[grant_q*UW +: UW],
                     s_axis_tstrb[grant_q*SW +: SW], s_axis_tdata[grant_q*DW +: DW]};

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            state_d = found ? PKT : IDLE;
            grant_d = found ? pick : grant_q;
        end else if (accept && s_axis_tlast[grant_q]) begin
            state_d = IDLE;
            last_d  = grant_q;
            cnt_d[grant_q*32 +: 32] = cnt_q[grant_q*32 +: 32] + 32'd1;
        end
        tready_d = '0;
        if (state_d == PKT) tready_d[grant_d] = room_nxt;
    end

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            last_q   <= GW'(N - 1);
            tready_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            tready_q <= tready_d;
            cnt_q    <= cnt_d;
        end
    end

    nf10_axis_reg_slice #(.W(PW)) u_slice (
        .clk          (axi_aclk),
        .rst          (axi_reset),
        .in_data_i    (beat),
        .in_valid_i   (accept),
        .in_room_nxt_o(room_nxt),
        .out_data_o   ({m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata}),
        .out_valid_o  (m_axis_tvalid),
        .out_ready_i  (m_axis_tready)
    );

    assign s_axis_tready = tready_q;
    assign pkt_cnt       = cnt_q;
endmodule

// File: tb/tb_nf10_decap_input_arbiter.sv
// tb_nf10_decap_input_arbiter: directed scenarios against the decap input arbiter
module tb_nf10_decap_input_arbiter;
    import nf10_decap_input_arbiter_pkg::*;
    localparam int DW = 256;
    localparam int SW = 32;
    localparam int UW = 128;
    localparam int NP = 4;

    typedef struct packed {
        logic          last;
        logic [UW-1:0] user;
        logic [SW-1:0] strb;
        logic [DW-1:0] data;
    } beat_t;

    logic              axi_aclk = 1'b0;
    logic              axi_reset = 1'b1;
    logic [NP*DW-1:0]  s_axis_tdata = '0;
    logic [NP*SW-1:0]  s_axis_tstrb = '0;
    logic [NP*UW-1:0]  s_axis_tuser = '0;
    logic [NP-1:0]     s_axis_tvalid = '0;
    logic [NP-1:0]     s_axis_tlast = '0;
    logic [NP-1:0]     s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [SW-1:0]     m_axis_tstrb;
    logic [UW-1:0]     m_axis_tuser;
    logic              m_axis_tvalid, m_axis_tlast;
    logic              m_axis_tready = 1'b0;
    logic [NP*32-1:0]  pkt_cnt;

    nf10_decap_input_arbiter dut (
        .axi_aclk(axi_aclk), .axi_reset(axi_reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .pkt_cnt(pkt_cnt)
    );

    always #5 axi_aclk = ~axi_aclk;

    int          errors = 0, checks = 0, cyc = 0, in_cnt = 0, out_cnt = 0, viol = 0;
    logic [NP-1:0] fire = '0, hold = '0;
    logic        ofire = 1'b0;
    beat_t       ocap;
    bit          rnd_rdy = 0, rdy = 1;
    logic [31:0] exp_cnt [NP];
    beat_t       src_q [NP][$];
    beat_t       out_q [$];
    beat_t       exp_q [$];

    function automatic beat_t mk_beat(int p, int k, int b, int n);
        beat_t t;
        nf10_tuser_t u;
        logic [31:0] w;
        w = {8'(p), 16'(k), 8'(b)};
        u = '0;
        u.len = 16'(n * 32);
        u.src = 8'(p);
        u.dst = 8'(k);
        t.data = {w, ~w, w ^ 32'h5A5A5A5A, w + 32'd1, {4{w}}};
        t.strb = (b == n - 1) ? (32'hFFFFFFFF >> p) : 32'hFFFFFFFF;
        t.user = u;
        t.last = (b == n - 1);
        return t;
    endfunction

    task automatic add_pkt(int p, int k, int n);
        for (int b = 0; b < n; b++) src_q[p].push_back(mk_beat(p, k, b, n));
        exp_cnt[p]++;
    endtask

    task automatic add_exp(int p, int k, int n);
        for (int b = 0; b < n; b++) exp_q.push_back(mk_beat(p, k, b, n));
    endtask

    function automatic int count_diffs();
        int d;
        d = (out_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
            if (out_q[i] !== exp_q[i]) d++;
        return d;
    endfunction

    function automatic logic [NP*32-1:0] exp_vec();
        logic [NP*32-1:0] v;
        for (int p = 0; p < NP; p++) v[p*32 +: 32] = exp_cnt[p];
        return v;
    endfunction

    function automatic bit all_empty();
        bit e;
        e = 1;
        for (int p = 0; p < NP; p++) if (src_q[p].size() != 0) e = 0;
        return e;
    endfunction

    // One clock: retire last cycle's handshakes, drive new inputs, note this cycle's handshakes.
    task automatic step();
        @(posedge axi_aclk);
        #1;
        cyc++;
        for (int p = 0; p < NP; p++)
            if (fire[p]) begin
                void'(src_q[p].pop_front());
                in_cnt++;
            end
        if (ofire) begin
            out_q.push_back(ocap);
            out_cnt++;
        end
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() != 0 && !hold[p]) begin
                s_axis_tvalid[p]          = 1'b1;
                s_axis_tlast[p]           = src_q[p][0].last;
                s_axis_tdata[p*DW +: DW]  = src_q[p][0].data;
                s_axis_tstrb[p*SW +: SW]  = src_q[p][0].strb;
                s_axis_tuser[p*UW +: UW]  = src_q[p][0].user;
            end else begin
                s_axis_tvalid[p] = 1'b0;
                s_axis_tlast[p]  = 1'b0;
            end
        end
        m_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy;
        fire  = s_axis_tvalid & s_axis_tready;
        ofire = m_axis_tvalid & m_axis_tready;
        ocap  = {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata};
        if ($countones(s_axis_tready) > 1 || in_cnt - out_cnt > 2) viol++;
    endtask

    task automatic drain(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (all_empty() && fire == '0 && !ofire && in_cnt == out_cnt) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        axi_reset = 1'b1;
        s_axis_tvalid = '0;
        s_axis_tlast = '0;
        m_axis_tready = 1'b0;
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            exp_cnt[p] = '0;
        end
        out_q.delete();
        exp_q.delete();
        fire = '0;
        ofire = 1'b0;
        hold = '0;
        in_cnt = 0;
        out_cnt = 0;
        viol = 0;
        rnd_rdy = 0;
        rdy = 1;
        repeat (2) @(posedge axi_aclk);
        #1 axi_reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        checks++;
        if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
        checks++;
        if (m_axis_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
        checks++;
        if (s_axis_tready !== 4'b0000) begin errors++; $display("FAIL reset_tready: got %b want 0000", s_axis_tready); end
        checks++;
        if (pkt_cnt !== '0) begin errors++; $display("FAIL reset_pkt_cnt: got %h want 0", pkt_cnt); end
    endtask

    task automatic test_single_packet();
        beat_t b;
        int c0, fi, fo, lo;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            b = mk_beat(0, 0, i, 4);
            b.user = 128'h0401AAAA;
            b.strb = 32'hFFFFFFFF;
            src_q[0].push_back(b);
            exp_q.push_back(b);
        end
        exp_cnt[0]++;
        c0 = cyc; fi = -1; fo = -1; lo = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (fire != '0 && fi < 0) fi = cyc - c0;
            if (ofire) begin
                if (fo < 0) fo = cyc - c0;
                lo = cyc - c0;
            end
        end
        checks++;
        if (fi !== 2) begin errors++; $display("FAIL single_first_tready: got cycle %0d want 2", fi); end
        checks++;
        if (fo !== 3) begin errors++; $display("FAIL single_first_out: got cycle %0d want 3", fo); end
        checks++;
        if (lo !== 6) begin errors++; $display("FAIL single_last_out: got cycle %0d want 6", lo); end
        checks++;
        if (out_q.size() !== 4) begin errors++; $display("FAIL single_beats: got %0d want 4", out_q.size()); end
        checks++;
        if (count_diffs() !== 0) begin errors++; $display("FAIL single_data: %0d beats differ, want 0", count_diffs()); end
        checks++;
        if (pkt_cnt !== exp_vec()) begin errors++; $display("FAIL single_pkt_cnt: got %h want %h", pkt_cnt, exp_vec()); end
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        for (int k = 0; k < 3; k++)
            for (int p = 0; p < NP; p++) begin
                add_pkt(p, k, 2);
                add_exp(p, k, 2);
            end
        drain(500, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL rr_drain: stream did not drain in 500 cycles"); end
        checks++;
        if (count_diffs() !== 0) begin errors++; $display("FAIL rr_order: %0d beats differ, want 0", count_diffs()); end
        checks++;
        if (pkt_cnt !== exp_vec()) begin errors++; $display("FAIL rr_pkt_cnt: got %h want %h", pkt_cnt, exp_vec()); end
        checks++;
        if (viol !== 0) begin errors++; $display("FAIL rr_protocol: got %0d violations want 0", viol); end
    endtask

    task automatic test_hold_grant();
        bit ok;
        do_reset();
        add_pkt(2, 0, 4);
        for (int i = 0; i < 20 && in_cnt < 2; i++) step();
        hold[2] = 1'b1;
        add_pkt(1, 0, 2);
        repeat (3) step();
        checks++;
        if (s_axis_tready !== 4'b0100) begin errors++; $display("FAIL hold_tready: got %b want 0100", s_axis_tready); end
        hold[2] = 1'b0;
        add_exp(2, 0, 4);
        add_exp(1, 0, 2);
        drain(200, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL hold_drain: stream did not drain in 200 cycles"); end
        checks++;
        if (count_diffs() !== 0) begin errors++; $display("FAIL hold_order: %0d beats differ, want 0", count_diffs()); end
        checks++;
        if (pkt_cnt !== exp_vec()) begin errors++; $display("FAIL hold_pkt_cnt: got %h want %h", pkt_cnt, exp_vec()); end
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        rdy = 0;
        add_pkt(0, 0, 4);
        add_exp(0, 0, 4);
        repeat (6) step();
        checks++;
        if (in_cnt !== 2) begin errors++; $display("FAIL bp_accepted: got %0d beats want 2", in_cnt); end
        checks++;
        if (s_axis_tready !== 4'b0000) begin errors++; $display("FAIL bp_tready: got %b want 0000", s_axis_tready); end
        checks++;
        if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid: got %b want 1", m_axis_tvalid); end
        rnd_rdy = 1;
        for (int k = 1; k <= 25; k++)
            for (int p = 0; p < NP; p++) add_pkt(p, k, (k + p) % 4 + 1);
        for (int k = 1; k <= 25; k++)
            for (int q = 1; q <= NP; q++) add_exp(q % NP, k, (k + q % NP) % 4 + 1);
        drain(5000, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL bp_drain: stream did not drain in 5000 cycles"); end
        checks++;
        if (count_diffs() !== 0) begin errors++; $display("FAIL bp_stream: %0d beats differ of %0d, want 0", count_diffs(), exp_q.size()); end
        checks++;
        if (pkt_cnt !== exp_vec()) begin errors++; $display("FAIL bp_pkt_cnt: got %h want %h", pkt_cnt, exp_vec()); end
        checks++;
        if (viol !== 0) begin errors++; $display("FAIL bp_occupancy: got %0d violations want 0", viol); end
        rnd_rdy = 0;
    endtask

    task automatic test_single_beat();
        bit ok;
        int ff, lf;
        do_reset();
        force dut.cnt_q = {96'h0, 32'hFFFFFFFF};
        step();
        release dut.cnt_q;
        step();
        checks++;
        if (pkt_cnt[31:0] !== 32'hFFFFFFFF) begin errors++; $display("FAIL sb_preload: got %h want ffffffff", pkt_cnt[31:0]); end
        exp_cnt[0] = 32'hFFFFFFFF;
        add_pkt(0, 0, 1);
        add_exp(0, 0, 1);
        drain(50, ok);
        checks++;
        if (pkt_cnt[31:0] !== 32'h0) begin errors++; $display("FAIL sb_wrap: got %h want 00000000", pkt_cnt[31:0]); end
        out_q.delete();
        exp_q.delete();
        for (int k = 1; k <= 3; k++) begin
            add_pkt(0, k, 1);
            add_pkt(3, k, 1);
            add_exp(3, k, 1);
            add_exp(0, k, 1);
        end
        ff = -1; lf = -1; ok = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (fire != '0) begin
                if (ff < 0) ff = cyc;
                lf = cyc;
            end
            if (all_empty() && fire == '0 && !ofire && in_cnt == out_cnt) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL sb_drain: stream did not drain in 100 cycles"); end
        checks++;
        if (lf - ff !== 10) begin errors++; $display("FAIL sb_spacing: got %0d cycles want 10", lf - ff); end
        checks++;
        if (count_diffs() !== 0) begin errors++; $display("FAIL sb_order: %0d beats differ, want 0", count_diffs()); end
        checks++;
        if (pkt_cnt !== exp_vec()) begin errors++; $display("FAIL sb_pkt_cnt: got %h want %h", pkt_cnt, exp_vec()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        add_pkt(1, 0, 1);
        add_exp(1, 0, 1);
        drain(50, ok);
        checks++;
        if (pkt_cnt !== exp_vec()) begin errors++; $display("FAIL rm_pre_cnt: got %h want %h", pkt_cnt, exp_vec()); end
        add_pkt(3, 0, 4);
        for (int i = 0; i < 20 && in_cnt < 2; i++) step();
        axi_reset = 1'b1;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rm_tvalid: got %b want 0", m_axis_tvalid); end
        checks++;
        if (s_axis_tready !== 4'b0000) begin errors++; $display("FAIL rm_tready: got %b want 0000", s_axis_tready); end
        checks++;
        if (pkt_cnt !== '0) begin errors++; $display("FAIL rm_pkt_cnt: got %h want 0", pkt_cnt); end
        do_reset();
        add_pkt(3, 1, 2);
        add_pkt(0, 1, 2);
        add_exp(0, 1, 2);
        add_exp(3, 1, 2);
        drain(100, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL rm_drain: stream did not drain in 100 cycles"); end
        checks++;
        if (count_diffs() !== 0) begin errors++; $display("FAIL rm_order: %0d beats differ, want 0", count_diffs()); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: still running at %0t, limit 1000000", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_hold_grant();
        test_backpressure();
        test_single_beat();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
